demux_capture: RTL and testbench
================================

# demux_capture

Sequential 1-to-N demultiplexer / deserializer: the receive end of a mux-driven serial link. It drives the slot index (`sel`) that steers an upstream N:1 mux and captures each incoming bit into lane `sel` of an assembly register. On the final slot it presents the completed N-bit word on a valid/ready output port. The block sits between a mux-based serializer and any parallel consumer, and holds one completed word while assembling the next.

## Interface
- `N`, 4, number of lanes / data bits per frame; power of two, ≥2.
- `SEL_W`, 2, width of `sel`; must equal log2(`N`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `din`  in  1  serial bit (the upstream mux output).
- `in_valid`  in  1  `din` carries a valid bit this cycle.
- `in_ready`  out  1  block accepts `din` this cycle.
- `sel`  out  `SEL_W`  lane index of the next data bit expected; drives upstream mux select.
- `par_slot`  out  1  next expected bit is the parity slot (only with `DEMUX_PARITY_EN`; otherwise tied 0).
- `dout`  out  `N`  completed word; lane k = bit received in slot k.
- `out_valid`  out  1  `dout` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `dout`.
- `out_perr`  out  1  parity error flag for `dout` (tied 0 without the macro).

## Operation
- An accept occurs when `in_valid && in_ready` are both high at a rising edge.
- Slot counter `cnt` runs 0..L-1, where L = `N` (or `N`+1 with parity). It advances by one per accept and wraps to 0 after slot L-1. It does not move without an accept.
- Data slot k (k < `N`): `asm[k] <= din`. Here `sel` = `cnt[SEL_W-1:0]` and `par_slot` = 0.
- Parity slot (cnt = `N`): `sel` = 0 and `par_slot` = 1.
- Final-slot accept loads the output register:
  - `dout <= asm` with the final bit merged in.
  - `out_valid <= 1`.
  - `out_perr <=` the parity result.
  - `asm` clears to 0.
- Output handshake: a word is consumed at an edge with `out_valid && out_ready`. If no new word loads on that edge, `out_valid <= 0`. `dout` and `out_perr` keep their last values after consumption.
- Backpressure: `in_ready = !(cnt == L-1 && out_valid && !out_ready)`. Only the final-slot bit is stalled; earlier slots of the next frame are accepted while a word is held.
- Simultaneous consume and final-slot accept at the same edge: the new word replaces the old one and `out_valid` stays 1. No bubble, no loss.
- `in_valid` gaps are allowed anywhere; `asm` and `cnt` hold during gaps.
- Outer state machine:
  - EMPTY (`out_valid` = 0) goes to FULL on a final-slot accept.
  - FULL goes to EMPTY on a consume with no final-slot accept.
  - FULL stays FULL on consume plus final-slot accept, or on neither.
- Reset values: `cnt` = 0, `asm` = 0, `sel` = 0, `par_slot` = 0, `dout` = 0, `out_valid` = 0, `out_perr` = 0. `in_ready` = 1 after reset.
- Reset mid-frame discards the partial frame and any held word. The next accepted bit is slot 0.

## Timing
- `sel`, `par_slot` and `in_ready` are combinational from registered state plus `out_valid`/`out_ready`. No combinational path from `din` or `in_valid` to any output.
- Latency: `dout`/`out_valid` update at the same edge that accepts the final-slot bit, i.e. visible the cycle after the final bit is presented.
- Minimum frame period is L cycles. Sustained throughput is one word per L cycles when `out_ready` is held high.
- `sel` changes only on the edge after an accept or on reset, so an upstream mux sees a stable select for the whole slot.

## Configuration
- `DEMUX_PARITY_EN` defined:
  - L = `N`+1; slot `N` carries an even-parity bit over the `N` data bits.
  - `out_perr <= ^{asm_final, parity_bit}`, which is 1 on a mismatch.
  - `par_slot` is active during the parity slot.
- `DEMUX_PARITY_EN` undefined:
  - L = `N`; there is no parity slot.
  - `out_perr` and `par_slot` are constant 0.
  - Port list is unchanged.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid` = 1 -> all outputs at reset values, `sel` = 0, no accept.
- Basic frame: send `din` = 0,1,0,1 in slots 0..3, `out_ready` = 0 -> `sel` steps 0,1,2,3. `dout` = 4'b1010 and `out_valid` = 1 the cycle after the 4th bit; they stay until `out_ready` = 1, then `out_valid` = 0.
- Backpressure: after the first word is held, stream a second frame 1,1,0,0 with `out_ready` = 0 -> slots 0..2 are accepted, `in_ready` = 0 at slot 3. Raise `out_ready` -> the slot-3 bit is accepted at the same edge and `dout` = 4'b0011 with `out_valid` still 1.
- Gaps and mid-frame reset: send bits 1,1 with `in_valid` gaps between them, assert `rst` for one cycle, then send 0,0,1,0 -> `sel` restarts at 0 and `dout` = 4'b0100.
- Continuous: `out_ready` = 1, `in_valid` = 1, 3 back-to-back frames -> one `out_valid` pulse per 4 cycles, `in_ready` never drops.
- With `DEMUX_PARITY_EN`: frame 1,0,1,0 + parity 0 -> `dout` = 4'b0101, `out_perr` = 0. Frame 1,0,1,0 + parity 1 -> `out_perr` = 1. `par_slot` = 1 only during slot 4.

Source files
------------

// File: rtl/demux_capture.sv
// rtl/demux_capture.sv - serial-to-parallel capture driving an upstream mux select.
// Optional parity slot enabled by defining DEMUX_PARITY_EN.
module demux_capture #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             par_slot,
  output logic [N-1:0]     dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr
);

  localparam int CNT_W = SEL_W + 1;
`ifdef DEMUX_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]   asm_reg;
  logic [N-1:0]   asm_merged;
  logic [N-1:0]   final_word;
  logic           final_perr;
  logic           last;
  logic           accept;
  logic           consume;

  assign last      = (cnt == CNT_W'(L - 1));
  assign out_valid = (state == FULL);
  assign in_ready  = !(last && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    asm_merged = asm_reg;
    if (cnt < CNT_W'(N)) asm_merged[cnt[SEL_W-1:0]] = din;
  end

`ifdef DEMUX_PARITY_EN
  // Final slot is the parity bit; data lanes are already complete in asm_reg.
  assign par_slot   = (cnt == CNT_W'(N));
  assign final_word = asm_reg;
  assign final_perr = ^{asm_reg, din};
`else
  assign par_slot   = 1'b0;
  assign final_word = asm_merged;
  assign final_perr = 1'b0;
`endif

  assign sel = par_slot ? '0 : cnt[SEL_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      cnt      <= '0;
      asm_reg  <= '0;
      dout     <= '0;
      out_perr <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          cnt      <= '0;
          asm_reg  <= '0;
          dout     <= final_word;
          out_perr <= final_perr;
        end else begin
          cnt     <= cnt + CNT_W'(1);
          asm_reg <= asm_merged;
        end
      end
      // A consume coinciding with a new load keeps the register full.
      case (state)
        EMPTY:   if (accept && last) state <= FULL;
        FULL:    if (consume && !(accept && last)) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_capture.sv
// tb/tb_demux_capture.sv - self-checking bench for demux_capture with a frame-level reference model.
module tb_demux_capture;

    localparam int N     = 4;
    localparam int SEL_W = 2;
`ifdef DEMUX_PARITY_EN
    localparam int L   = N + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int L   = N;
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             par_slot;
    logic [N-1:0]     dout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_perr;

    demux_capture #(.N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .par_slot(par_slot), .dout(dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_perr(out_perr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic         bits[$];
    logic [N-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_perr;

    function automatic logic final_bit(input logic [N-1:0] w);
        return PAR ? ^w : w[N-1];
    endfunction

    task automatic model_reset();
        bits.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic check_regs();
        chk("dout", dout === exp_dout, dout, exp_dout);
        chk("out_valid", out_valid === exp_valid, out_valid, exp_valid);
        chk("out_perr", out_perr === exp_perr, out_perr, exp_perr);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b1; din = 1'b1; out_ready = 1'($urandom);
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        #1;
        check_regs();
        chk("rst_sel", sel === SEL_W'(0), sel, 0);
        chk("rst_par_slot", par_slot === 1'b0, par_slot, 0);
        chk("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    endtask

    task automatic cycle(input logic d, input logic v, input logic r);
        logic exp_ready, acc, cons, loaded, perr_acc, exp_par;
        int   slot;
        logic [SEL_W-1:0] exp_sel;
        din = d; in_valid = v; out_ready = r;
        #1;
        slot      = bits.size();
        exp_ready = !(slot == L - 1 && exp_valid && !r);
        exp_sel   = (slot < N) ? SEL_W'(slot) : SEL_W'(0);
        exp_par   = PAR && (slot == N);
        chk("in_ready", in_ready === exp_ready, in_ready, exp_ready);
        chk("sel", sel === exp_sel, sel, exp_sel);
        chk("par_slot", par_slot === exp_par, par_slot, exp_par);
        acc    = v && exp_ready;
        cons   = exp_valid && r;
        loaded = 1'b0;
        @(posedge clk);
        if (acc) begin
            bits.push_back(d);
            if (bits.size() == L) begin
                perr_acc = 1'b0;
                for (int k = 0; k < N; k++) exp_dout[k] = bits[k];
                for (int k = 0; k < L; k++) perr_acc ^= bits[k];
                exp_perr  = PAR ? perr_acc : 1'b0;
                exp_valid = 1'b1;
                loaded    = 1'b1;
                bits.delete();
            end
        end
        if (cons && !loaded) exp_valid = 1'b0;
        @(negedge clk);
        check_regs();
    endtask

    task automatic send_prefix(input logic [N-1:0] w, input logic r);
        for (int k = 0; k < L - 1; k++) cycle(w[k], 1'b1, r);
    endtask

    initial begin
        model_reset();
        do_reset(2);

        send_prefix(4'b1010, 1'b0);
        cycle(final_bit(4'b1010), 1'b1, 1'b0);
        chk("basic_dout", dout === 4'b1010, dout, 4'b1010);
        chk("basic_valid", out_valid === 1'b1, out_valid, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("basic_hold", out_valid === 1'b1, out_valid, 1);

        send_prefix(4'b0011, 1'b0);
        cycle(final_bit(4'b0011), 1'b1, 1'b0);
        chk("bp_in_ready", in_ready === 1'b0, in_ready, 0);
        chk("bp_old_word", dout === 4'b1010, dout, 4'b1010);
        cycle(final_bit(4'b0011), 1'b1, 1'b1);
        chk("bp_dout", dout === 4'b0011, dout, 4'b0011);
        chk("bp_valid", out_valid === 1'b1, out_valid, 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("consume_valid", out_valid === 1'b0, out_valid, 0);
        chk("consume_keep", dout === 4'b0011, dout, 4'b0011);

        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        do_reset(1);
        send_prefix(4'b0100, 1'b1);
        cycle(final_bit(4'b0100), 1'b1, 1'b1);
        chk("gap_dout", dout === 4'b0100, dout, 4'b0100);

        for (int f = 0; f < 3; f++) begin
            logic [N-1:0] w;
            w = N'($urandom);
            send_prefix(w, 1'b1);
            cycle(final_bit(w), 1'b1, 1'b1);
            chk("cont_dout", dout === w, dout, w);
        end

`ifdef DEMUX_PARITY_EN
        send_prefix(4'b0101, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("par_ok_dout", dout === 4'b0101, dout, 4'b0101);
        chk("par_ok_perr", out_perr === 1'b0, out_perr, 0);
        send_prefix(4'b0101, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("par_bad_perr", out_perr === 1'b1, out_perr, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
